// File: rtl/fp_special_case_pipe.sv
// Two-stage IEEE-754 special-operand classifier and resolver for the add/sub datapath.
// Pairs of finite nonzero operands leave with out_special=0 for the alignment adder.
module fp_special_case_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FTZ   = 0,
    parameter int TAG_W = 4,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic             out_special,
    output logic [2:0]       out_cls_a,
    output logic [2:0]       out_cls_b,
    output logic [TAG_W-1:0] out_tag,
    output logic             flag_invalid,
    input  logic             flag_clr
);

    localparam logic [2:0] CLS_ZERO = 3'b000;
    localparam logic [2:0] CLS_SUB  = 3'b001;
    localparam logic [2:0] CLS_NORM = 3'b011;
    localparam logic [2:0] CLS_INF  = 3'b100;
    localparam logic [2:0] CLS_NAN  = 3'b110;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Under FTZ a subnormal is reported as zero and resolved as a zero of its own sign.
    function automatic logic [2:0] classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = x[W-2:MAN_W];
        m = x[MAN_W-1:0];
        if (&e)
            classify = (|m) ? CLS_NAN : CLS_INF;
        else if (|e)
            classify = CLS_NORM;
        else if ((|m) && (FTZ == 0))
            classify = CLS_SUB;
        else
            classify = CLS_ZERO;
    endfunction

    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [2:0]       s1_cls_a;
    logic [2:0]       s1_cls_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_invalid;
    logic             s1_load;
    logic             s2_load;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and its payload stable until that edge. Each stage refills
    // whenever it is empty or its contents move on in the same cycle.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Stage 1: operands with B's effective sign already applied, plus classes and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cls_a <= CLS_ZERO;
            s1_cls_b <= CLS_ZERO;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a     <= in_a;
                s1_b     <= {in_b[W-1] ^ in_sub, in_b[W-2:0]};
                s1_cls_a <= classify(in_a);
                s1_cls_b <= classify(in_b);
                s1_tag   <= in_tag;
            end
        end
    end

    logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic         sa, sb;
    logic [W-1:0] res_result;
    logic         res_special;
    logic         res_invalid;

    assign a_nan  = (s1_cls_a == CLS_NAN);
    assign b_nan  = (s1_cls_b == CLS_NAN);
    assign a_inf  = (s1_cls_a == CLS_INF);
    assign b_inf  = (s1_cls_b == CLS_INF);
    assign a_zero = (s1_cls_a == CLS_ZERO);
    assign b_zero = (s1_cls_b == CLS_ZERO);
    assign sa     = s1_a[W-1];
    assign sb     = s1_b[W-1];

    // Priority: NaN, inf/inf, single inf, zero/zero, single zero, then arithmetic needed.
    always_comb begin
        res_result  = '0;
        res_special = 1'b1;
        res_invalid = 1'b0;
        if (a_nan || b_nan) begin
            res_result  = QNAN;
            res_invalid = (a_nan && !s1_a[MAN_W-1]) || (b_nan && !s1_b[MAN_W-1]);
        end else if (a_inf && b_inf) begin
            if (sa != sb) begin
                res_result  = QNAN;
                res_invalid = 1'b1;
            end else begin
                res_result = s1_a;
            end
        end else if (a_inf) begin
            res_result = s1_a;
        end else if (b_inf) begin
            res_result = s1_b;
        end else if (a_zero && b_zero) begin
            res_result = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            res_result = s1_b;
        end else if (b_zero) begin
            res_result = s1_a;
        end else begin
            res_special = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_special <= 1'b0;
            out_cls_a   <= CLS_ZERO;
            out_cls_b   <= CLS_ZERO;
            out_tag     <= '0;
            s2_invalid  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= res_result;
                out_special <= res_special;
                out_cls_a   <= s1_cls_a;
                out_cls_b   <= s1_cls_b;
                out_tag     <= s1_tag;
                s2_invalid  <= res_invalid;
            end
        end
    end

    // Setting on an invalid result's handshake takes precedence over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flag_invalid <= 1'b0;
        else if (out_valid && out_ready && s2_invalid)
            flag_invalid <= 1'b1;
        else if (flag_clr)
            flag_invalid <= 1'b0;
    end

endmodule

// File: doc/fp_special_case_pipe.md
Name: fp_special_case_pipe

Overview:
Parametrised, pipelined IEEE-754 special-operand classifier and resolver for the floating-point add/subtract datapath; it is the successor to the combinational special-case decoder. It classifies both operands and resolves every non-arithmetic result: zero, infinity, NaN, and, when FTZ=1, subnormal inputs. Only pairs where both operands are finite and nonzero are flagged for the mantissa-alignment adder. It adds a valid/ready handshake, a subtract mode, canonical NaN generation, correct signed-zero rules, a sticky invalid flag, and arbitrary exponent/mantissa widths.

Parameters:
EXP_W, 8, exponent field width (W = 1+EXP_W+MAN_W total)
MAN_W, 23, mantissa (fraction) field width
FTZ, 0, 1 = subnormal inputs are flushed to signed zero before resolution
TAG_W, 4, width of the sideband tag carried alongside each operation

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair this cycle
in_a  input  W  operand A
in_b  input  W  operand B
in_sub  input  1  1 = compute A-B (B sign inverted), 0 = A+B
in_tag  input  TAG_W  sideband tag, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  W  resolved result (all zeros when out_special=0)
out_special  output  1  1 = out_result is final; 0 = both operands are finite nonzero, so the arithmetic path is required
out_cls_a  output  3  class of A
out_cls_b  output  3  class of B
out_tag  output  TAG_W  tag of this result
flag_invalid  output  1  sticky invalid-operation flag
flag_clr  input  1  synchronous clear of flag_invalid

Behaviour:
- Class codes: 000 zero, 001 subnormal, 011 normal (any mantissa, including 0), 100 infinity, 110 NaN.
  - bit0 = finite nonzero.
  - Codes 010, 101 and 111 are never produced.
  - With FTZ=1, a subnormal is reported as 000 and treated as a zero of the same sign.
- Pipeline: two register stages. S1 registers the operands, the effective B sign (sb^in_sub), both classes and the tag. S2 registers the resolved result.
- Latency: exactly 2 cycles from input handshake to out_valid when out_ready=1. Throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid&ready.
  - S2 loads when it is empty or out_ready=1. S1 loads when it is empty or S2 loads.
  - in_ready = !s1_valid | s2_load. This is combinational from out_ready, and no other combinational path from input to output exists.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Resolution priority, using B' = B with the effective sign:
  1. Either operand NaN: result is the canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0). Invalid if either NaN is signalling (mantissa MSB 0).
  2. Inf and Inf: if the signs of A and B' differ, result is the canonical qNaN and invalid. Otherwise the result is that infinity.
  3. Exactly one operand infinite: result is that infinity (B' if B).
  4. Zero and zero: result sign = sa & sb' (round-to-nearest rule), exponent and mantissa 0.
  5. Exactly one operand zero: result is the other operand (B' if B), bit-exact.
  6. Both finite nonzero: out_special=0, out_result=0.
- flag_invalid:
  - Sets on the output handshake of a result marked invalid.
  - Cleared by flag_clr=1. If set and clear occur in the same cycle, set wins.
  - It is never cleared by any other event except reset.
- Reset (rst_n low, asynchronous): both stage valids=0, out_valid=0, out_special=0, out_result=0, out_cls_a/b=000, out_tag=0, flag_invalid=0. in_ready=1 from the first cycle after deassertion.
- Reset mid-operation discards all in-flight pairs. No partial result is ever emitted.
- Stall with a full pipeline: in_ready=0, and no input is lost or duplicated.

Test Plan:
1. Handshake and latency:
   - Stimulus: A=0x3F800000, B=0x40000000, in_sub=0, tag=5, out_ready=1.
   - Required: cycle+2 gives out_valid=1, out_special=0, cls 011/011, tag=5.
   - Also drive A=0x3F800000 with B=0x00000000. Required: out_special=1, result 0x3F800000 (a normal with zero mantissa is classed 011).
2. Signed zeros:
   - 0x80000000 + 0x80000000 → 0x80000000.
   - 0x80000000 − 0x80000000 → 0x00000000.
   - 0x00000000 − 0x3F800000 → 0xBF800000.
3. Infinities and NaN:
   - 0x7F800000 − 0x7F800000 → 0x7FC00000, flag_invalid=1.
   - 0x7F800000 + 0xFF800000 → 0x7FC00000, flag_invalid=1.
   - 0xFF800000 + 0x3F800000 → 0xFF800000.
   - 0x7FC00001 + 1.0 → 0x7FC00000, flag unchanged.
   - 0x7F800001 + 1.0 → 0x7FC00000, invalid.
4. FTZ:
   - With FTZ=1: 0x00000001 + 0x3F800000 → cls_a=000, result 0x3F800000.
   - With FTZ=0: cls_a=001, out_special=0.
5. Backpressure:
   - Stimulus: stream 6 tagged pairs while holding out_ready=0 for 4 cycles.
   - Required: in_ready drops after 2 accepts, outputs hold stable, and all 6 tags emerge in order with no loss or duplication.
   - Also: flag_clr in the same cycle as an invalid output handshake → flag stays 1.
6. Reset:
   - Assert rst_n=0 with 2 pairs in flight.
   - Required: out_valid=0 immediately and flag_invalid=0. After release, no stale result appears.
   - Check the same with EXP_W=11, MAN_W=52: 0x7FF0…0 − 0x7FF0…0 → 0x7FF8000000000000.
